// File: rtl/kbd_scan_ctrl.sv
// Keyboard matrix scan controller: one-hot column strobe, row sampling,
// whole-frame debounce and a debounced key map with change/pending flags.
`timescale 1ns/1ps
module kbd_scan_ctrl #(
  parameter int COLS     = 10,
  parameter int ROWS     = 9,
  parameter int SETTLE   = 2,
  parameter int DEBOUNCE = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            scan_en,
  input  logic [ROWS-1:0] kbd_row,
  output logic [COLS-1:0] kbd_col,
  input  logic [3:0]      rd_col,
  output logic [ROWS-1:0] rd_row_data,
  output logic            key_change,
  output logic            pending,
  input  logic            pending_clr
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TW = $clog2(SETTLE + 1);
  localparam int SW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_FRAME
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nx;
  logic [ROWS-1:0]            r_sync1;
  logic [ROWS-1:0]            r_sync2;
  logic [CW-1:0]              r_col;
  logic [TW-1:0]              r_tick_cnt;
  logic [SW-1:0]              r_stable_cnt;
  logic [SW-1:0]              w_stable_nx;
  logic [COLS-1:0][ROWS-1:0]  r_cur;
  logic [COLS-1:0][ROWS-1:0]  r_prev;
  logic [COLS-1:0][ROWS-1:0]  r_deb;
  logic                       r_key_change;
  logic                       r_pending;
  logic                       w_sample;
  logic                       w_last_col;
  logic                       w_accept;
  logic                       w_set;

  assign w_sample   = tick && (r_tick_cnt == TW'(SETTLE - 1));
  assign w_last_col = (r_col == CW'(COLS - 1));
  assign w_accept   = (w_stable_nx == SW'(DEBOUNCE)) && (r_cur != r_deb);
  assign w_set      = (r_state == S_FRAME) && w_accept;

  assign kbd_col    = (r_state == S_DRIVE) ? (COLS'(1) << r_col) : '0;
  assign key_change = r_key_change;
  assign pending    = r_pending;

  // two-flop synchronizer for the asynchronous row inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= kbd_row;
      r_sync2 <= r_sync1;
    end
  end

  // scan state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // next scan state; an abort takes priority over a sample tick
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (scan_en && tick) w_state_nx = S_DRIVE;
      S_DRIVE: begin
        if (!scan_en)                    w_state_nx = S_IDLE;
        else if (w_sample && w_last_col) w_state_nx = S_FRAME;
      end
      S_FRAME: w_state_nx = scan_en ? S_DRIVE : S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // stable-frame count after this frame, saturating at DEBOUNCE
  always_comb begin
    w_stable_nx = SW'(1);
    if (r_cur == r_prev) begin
      if (r_stable_cnt == SW'(DEBOUNCE)) w_stable_nx = r_stable_cnt;
      else                               w_stable_nx = r_stable_cnt + SW'(1);
    end
  end

  // column walk, row capture and frame-level debounce
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col        <= '0;
      r_tick_cnt   <= '0;
      r_stable_cnt <= '0;
      r_cur        <= '0;
      r_prev       <= '0;
      r_deb        <= '0;
      r_key_change <= 1'b0;
    end else begin
      r_key_change <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (scan_en && tick) begin
            r_col      <= '0;
            r_tick_cnt <= '0;
          end
        end
        S_DRIVE: begin
          if (!scan_en) begin
            r_col        <= '0;
            r_tick_cnt   <= '0;
            r_stable_cnt <= '0;
          end else if (w_sample) begin
            r_cur[r_col] <= r_sync2;
            r_tick_cnt   <= '0;
            if (!w_last_col) r_col <= r_col + CW'(1);
          end else if (tick) begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
          end
        end
        S_FRAME: begin
          r_prev       <= r_cur;
          r_stable_cnt <= w_stable_nx;
          r_col        <= '0;
          r_tick_cnt   <= '0;
          if (w_accept) begin
            r_deb        <= r_cur;
            r_key_change <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // sticky change flag; a new change beats a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_pending <= 1'b0;
    else if (w_set)       r_pending <= 1'b1;
    else if (pending_clr) r_pending <= 1'b0;
  end

  // combinational readback of one debounced column
  always_comb begin
    rd_row_data = '0;
    if (rd_col < 4'(COLS)) rd_row_data = r_deb[rd_col];
  end

endmodule
